// File: rtl/piso.sv
// piso: N-bit parallel-in serial-out, MSB first; first bit appears 1 cycle after transfer, LSB cycle carries the enable strobe.
// Backpressure: ready only while idle or in the LSB cycle; `define PISO_HOLD_BUF_EN adds a one-entry holding register (ready = holding empty).
module piso #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         data_valid,
  output logic         ready,
  output logic         serial_out,
  output logic         enable,
  output logic         busy
);

  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic          ser_d, en_d;
  logic          xfer, slot_free, load;
  logic [N-1:0]  load_dat;

  // A new symbol may start when idle or while the current LSB is on the line.
  assign slot_free = (state_q == IDLE) || (bit_cnt_q == '0);
  assign busy      = (state_q == SHIFT);

`ifdef PISO_HOLD_BUF_EN
  logic         hold_vld_q, hold_vld_d;
  logic [N-1:0] hold_dat_q, hold_dat_d;

  assign ready    = !hold_vld_q;
  assign xfer     = data_valid && ready;
  assign load     = slot_free && (hold_vld_q || xfer);
  assign load_dat = hold_vld_q ? hold_dat_q : data_in;

  // Symbols arriving mid-shift park here; a free slot always drains it first.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (slot_free) begin
      hold_vld_d = 1'b0;
    end else if (xfer) begin
      hold_vld_d = 1'b1;
      hold_dat_d = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end
`else
  assign ready    = slot_free;
  assign xfer     = data_valid && ready;
  assign load     = xfer;
  assign load_dat = data_in;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ser_d     = 1'b0;
    en_d      = 1'b0;
    if (load) begin
      state_d   = SHIFT;
      bit_cnt_d = CW'(N - 1);
      ser_d     = load_dat[N-1];
      sh_d      = {load_dat[N-2:0], 1'b0};
    end else if (state_q == SHIFT) begin
      if (bit_cnt_q == '0) begin
        state_d = IDLE;
        sh_d    = '0;
      end else begin
        bit_cnt_d = bit_cnt_q - CW'(1);
        ser_d     = sh_q[N-1];
        sh_d      = {sh_q[N-2:0], 1'b0};
        // Next cycle carries the LSB.
        en_d      = (bit_cnt_q == CW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      serial_out <= 1'b0;
      enable     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      serial_out <= ser_d;
      enable     <= en_d;
    end
  end

endmodule
